// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the execute stage: word/register widths, ALU opcodes,
// the EX-stage FSM states and the latched ID/EX bundle.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } exstate_t;

  typedef struct packed {
    logic     valid;
    aluop_t   aluop;
    regbits_t rs;
    regbits_t rt;
    word_t    rs_val;
    word_t    rt_val;
    word_t    imm;
    logic     alusrc;
    regbits_t rd;
    logic     regwen;
    logic     ovf_chk;
  } idex_t;

  localparam idex_t IDEX_RESET = '{
    valid:   1'b0,
    aluop:   ALU_ADD,
    rs:      5'd0,
    rt:      5'd0,
    rs_val:  32'd0,
    rt_val:  32'd0,
    imm:     32'd0,
    alusrc:  1'b0,
    rd:      5'd0,
    regwen:  1'b0,
    ovf_chk: 1'b0
  };

  // Register 0 is hardwired to zero, so it can never be a forwarding target.
  function automatic logic fwd_hit(logic src_wen, regbits_t src_rd, regbits_t rs);
    return src_wen && (src_rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/alu_ex_stage_if.sv
// Bundle of ID/EX inputs, forwarding sources, ALU ports and EX/MEM outputs
// around the execute stage.
interface alu_ex_stage_if;
  import cpu_types_pkg::*;

  logic     id_valid;
  logic     id_ready;
  aluop_t   id_aluop;
  regbits_t id_rs;
  regbits_t id_rt;
  word_t    id_rs_val;
  word_t    id_rt_val;
  word_t    id_imm;
  logic     id_alusrc;
  regbits_t id_rd;
  logic     id_regwen;
  logic     id_ovf_chk;

  logic     mem_regwen;
  logic     wb_regwen;
  regbits_t mem_rd;
  regbits_t wb_rd;
  word_t    mem_val;
  word_t    wb_val;

  logic     stall;
  logic     flush;

  word_t    alu_porta;
  word_t    alu_portb;
  aluop_t   alu_op;
  word_t    alu_out;
  logic     alu_neg;
  logic     alu_zero;
  logic     alu_over;

  logic     ex_valid;
  word_t    ex_result;
  regbits_t ex_rd;
  logic     ex_regwen;
  logic     ex_zero;
  logic     ex_neg;
  logic     ex_ovf_exc;

  modport master (
    output id_valid, id_aluop, id_rs, id_rt, id_rs_val, id_rt_val, id_imm,
           id_alusrc, id_rd, id_regwen, id_ovf_chk,
           mem_regwen, wb_regwen, mem_rd, wb_rd, mem_val, wb_val,
           stall, flush, alu_out, alu_neg, alu_zero, alu_over,
    input  id_ready, alu_porta, alu_portb, alu_op,
           ex_valid, ex_result, ex_rd, ex_regwen, ex_zero, ex_neg, ex_ovf_exc
  );

  modport slave (
    input  id_valid, id_aluop, id_rs, id_rt, id_rs_val, id_rt_val, id_imm,
           id_alusrc, id_rd, id_regwen, id_ovf_chk,
           mem_regwen, wb_regwen, mem_rd, wb_rd, mem_val, wb_val,
           stall, flush, alu_out, alu_neg, alu_zero, alu_over,
    output id_ready, alu_porta, alu_portb, alu_op,
           ex_valid, ex_result, ex_rd, ex_regwen, ex_zero, ex_neg, ex_ovf_exc
  );

endinterface

// File: rtl/alu_ex_stage_forward_unit.sv
// Combinational operand bypass: picks MEM, then WB, then the latched register
// value for one source operand.
module forward_unit
  import cpu_types_pkg::*;
(
  input  regbits_t src_reg,
  input  word_t    src_val,
  input  logic     mem_regwen,
  input  regbits_t mem_rd,
  input  word_t    mem_val,
  input  logic     wb_regwen,
  input  regbits_t wb_rd,
  input  word_t    wb_val,
  output word_t    fwd_val
);

  always_comb begin
    fwd_val = src_val;
    // MEM holds the younger result, so it wins over WB.
    if (fwd_hit(mem_regwen, mem_rd, src_reg)) begin
      fwd_val = mem_val;
    end else if (fwd_hit(wb_regwen, wb_rd, src_reg)) begin
      fwd_val = wb_val;
    end
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ID/EX latch, operand forwarding, ALU drive, EX/MEM capture and
// a sticky signed-overflow trap that blocks the pipe until flush.
module alu_ex_stage
  import cpu_types_pkg::*;
(
  input logic           clk,
  input logic           rst,
  alu_ex_stage_if.slave bus
);

  exstate_t state_reg, state_next;
  idex_t    idex_reg;
  idex_t    idex_load;
  logic     advance;
  logic     trap_fire;

  logic     ex_valid_reg;
  word_t    ex_result_reg;
  regbits_t ex_rd_reg;
  logic     ex_regwen_reg;
  logic     ex_zero_reg;
  logic     ex_neg_reg;
  logic     ex_ovf_exc_reg;

  regbits_t opnd_reg [2];
  word_t    opnd_val [2];
  word_t    opnd_fwd [2];

  assign advance   = (state_reg == RUN) && !bus.stall && !bus.flush;
  assign trap_fire = advance && idex_reg.valid && idex_reg.ovf_chk && bus.alu_over;
  assign bus.id_ready = advance;

  always_comb begin
    idex_load = '{
      valid:   bus.id_valid,
      aluop:   bus.id_aluop,
      rs:      bus.id_rs,
      rt:      bus.id_rt,
      rs_val:  bus.id_rs_val,
      rt_val:  bus.id_rt_val,
      imm:     bus.id_imm,
      alusrc:  bus.id_alusrc,
      rd:      bus.id_rd,
      regwen:  bus.id_regwen,
      ovf_chk: bus.id_ovf_chk
    };
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (trap_fire) state_next = TRAP;
      TRAP:    if (bus.flush) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // The op younger than a trapping one is dropped rather than held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_reg <= IDEX_RESET;
    end else if (bus.flush) begin
      idex_reg.valid <= 1'b0;
    end else if (advance) begin
      if (trap_fire) begin
        idex_reg.valid <= 1'b0;
      end else begin
        idex_reg <= idex_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_result_reg  <= '0;
      ex_rd_reg      <= '0;
      ex_regwen_reg  <= 1'b0;
      ex_zero_reg    <= 1'b0;
      ex_neg_reg     <= 1'b0;
      ex_ovf_exc_reg <= 1'b0;
    end else if (bus.flush) begin
      ex_valid_reg   <= 1'b0;
      ex_regwen_reg  <= 1'b0;
      ex_ovf_exc_reg <= 1'b0;
    end else if (advance) begin
      ex_valid_reg   <= idex_reg.valid;
      ex_result_reg  <= bus.alu_out;
      ex_rd_reg      <= idex_reg.rd;
      ex_regwen_reg  <= idex_reg.regwen && !trap_fire;
      ex_zero_reg    <= bus.alu_zero;
      ex_neg_reg     <= bus.alu_neg;
      ex_ovf_exc_reg <= trap_fire;
    end else if (state_reg == TRAP) begin
      // The trapping op is presented downstream for exactly one cycle.
      ex_valid_reg <= 1'b0;
    end
  end

  assign opnd_reg[0] = idex_reg.rs;
  assign opnd_reg[1] = idex_reg.rt;
  assign opnd_val[0] = idex_reg.rs_val;
  assign opnd_val[1] = idex_reg.rt_val;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      forward_unit u_fwd (
        .src_reg    (opnd_reg[gi]),
        .src_val    (opnd_val[gi]),
        .mem_regwen (bus.mem_regwen),
        .mem_rd     (bus.mem_rd),
        .mem_val    (bus.mem_val),
        .wb_regwen  (bus.wb_regwen),
        .wb_rd      (bus.wb_rd),
        .wb_val     (bus.wb_val),
        .fwd_val    (opnd_fwd[gi])
      );
    end
  endgenerate

  assign bus.alu_porta = opnd_fwd[0];
  assign bus.alu_portb = idex_reg.alusrc ? idex_reg.imm : opnd_fwd[1];
  assign bus.alu_op    = idex_reg.aluop;

  assign bus.ex_valid   = ex_valid_reg;
  assign bus.ex_result  = ex_result_reg;
  assign bus.ex_rd      = ex_rd_reg;
  assign bus.ex_regwen  = ex_regwen_reg;
  assign bus.ex_zero    = ex_zero_reg;
  assign bus.ex_neg     = ex_neg_reg;
  assign bus.ex_ovf_exc = ex_ovf_exc_reg;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed scenarios plus a randomized
// stream checked against a cycle-level behavioural model of the stage.
module tb_alu_ex_stage;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  alu_ex_stage_if bus ();

  alu_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: {signed_overflow, result}
  function automatic logic [32:0] alu_ref(aluop_t op, word_t a, word_t b);
    longint s;
    word_t  r;
    logic   ov;
    ov = 1'b0;
    r  = '0;
    s  = 0;
    case (op)
      ALU_ADD: begin
        s  = longint'($signed(a)) + longint'($signed(b));
        r  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUB: begin
        s  = longint'($signed(a)) - longint'($signed(b));
        r  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = '0;
    endcase
    return {ov, r};
  endfunction

  // Stand-in for the external ALU in the datapath.
  always_comb begin
    logic [32:0] res;
    res          = alu_ref(bus.alu_op, bus.alu_porta, bus.alu_portb);
    bus.alu_out  = res[31:0];
    bus.alu_over = res[32];
    bus.alu_neg  = res[31];
    bus.alu_zero = (res[31:0] == 32'd0);
  end

  function automatic word_t fwd_ref(regbits_t r, word_t latched);
    if (r != 5'd0 && bus.mem_regwen && bus.mem_rd == r) return bus.mem_val;
    if (r != 5'd0 && bus.wb_regwen && bus.wb_rd == r) return bus.wb_val;
    return latched;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid   = 1'b0;
    bus.id_aluop   = ALU_ADD;
    bus.id_rs      = '0;
    bus.id_rt      = '0;
    bus.id_rs_val  = '0;
    bus.id_rt_val  = '0;
    bus.id_imm     = '0;
    bus.id_alusrc  = 1'b0;
    bus.id_rd      = '0;
    bus.id_regwen  = 1'b0;
    bus.id_ovf_chk = 1'b0;
    bus.mem_regwen = 1'b0;
    bus.wb_regwen  = 1'b0;
    bus.mem_rd     = '0;
    bus.wb_rd      = '0;
    bus.mem_val    = '0;
    bus.wb_val     = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic drive(input aluop_t op, input regbits_t rs, input word_t rsv,
                       input regbits_t rt, input word_t rtv, input word_t imm,
                       input logic alusrc, input regbits_t rd, input logic regwen,
                       input logic ovf);
    bus.id_valid   = 1'b1;
    bus.id_aluop   = op;
    bus.id_rs      = rs;
    bus.id_rs_val  = rsv;
    bus.id_rt      = rt;
    bus.id_rt_val  = rtv;
    bus.id_imm     = imm;
    bus.id_alusrc  = alusrc;
    bus.id_rd      = rd;
    bus.id_regwen  = regwen;
    bus.id_ovf_chk = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) tick();
    checks += 6;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", bus.ex_valid); end
    if (bus.ex_result !== 32'd0) begin failures++; $display("FAIL reset_ex_result got=%h exp=0", bus.ex_result); end
    if (bus.ex_ovf_exc !== 1'b0) begin failures++; $display("FAIL reset_ex_ovf got=%b exp=0", bus.ex_ovf_exc); end
    if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL reset_id_ready got=%b exp=1", bus.id_ready); end
    if (bus.alu_op !== ALU_ADD) begin failures++; $display("FAIL reset_alu_op got=%0d exp=%0d", bus.alu_op, ALU_ADD); end
    if (bus.alu_porta !== 32'd0) begin failures++; $display("FAIL reset_porta got=%h exp=0", bus.alu_porta); end
    rst = 1'b0;
    tick();
    // Put a live result on ex_* and then reset asynchronously mid-cycle.
    drive(ALU_ADD, 5'd1, 32'd1, 5'd0, 32'd0, 32'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    checks += 2;
    if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", bus.ex_valid); end
    if (bus.ex_result !== 32'd3) begin failures++; $display("FAIL pre_reset_result got=%h exp=3", bus.ex_result); end
    #2;
    rst = 1'b1;
    #1;
    checks += 5;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", bus.ex_valid); end
    if (bus.ex_result !== 32'd0) begin failures++; $display("FAIL async_reset_result got=%h exp=0", bus.ex_result); end
    if (bus.ex_rd !== 5'd0) begin failures++; $display("FAIL async_reset_rd got=%0d exp=0", bus.ex_rd); end
    if (bus.ex_regwen !== 1'b0) begin failures++; $display("FAIL async_reset_regwen got=%b exp=0", bus.ex_regwen); end
    if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b exp=1", bus.id_ready); end
    #2;
    rst = 1'b0;
    tick();
    $display("txn reset: async reset cleared ex_* without a clock edge");
  endtask

  task automatic test_basic();
    drive(ALU_ADD, 5'd1, 32'd5, 5'd0, 32'd0, 32'd7, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    checks += 3;
    if (bus.alu_portb !== 32'd7) begin failures++; $display("FAIL basic_portb got=%h exp=7", bus.alu_portb); end
    if (bus.alu_porta !== 32'd5) begin failures++; $display("FAIL basic_porta got=%h exp=5", bus.alu_porta); end
    if (bus.alu_op !== ALU_ADD) begin failures++; $display("FAIL basic_op got=%0d exp=%0d", bus.alu_op, ALU_ADD); end
    tick();
    checks += 5;
    if (bus.ex_result !== 32'd12) begin failures++; $display("FAIL basic_result got=%h exp=c", bus.ex_result); end
    if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.ex_valid); end
    if (bus.ex_zero !== 1'b0) begin failures++; $display("FAIL basic_zero got=%b exp=0", bus.ex_zero); end
    if (bus.ex_rd !== 5'd4) begin failures++; $display("FAIL basic_rd got=%0d exp=4", bus.ex_rd); end
    if (bus.ex_regwen !== 1'b1) begin failures++; $display("FAIL basic_regwen got=%b exp=1", bus.ex_regwen); end
    $display("txn basic: ADD 5+7 -> %h", bus.ex_result);
  endtask

  task automatic test_forwarding();
    drive(ALU_ADD, 5'd3, 32'h11, 5'd3, 32'h22, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    idle();
    bus.mem_regwen = 1'b1; bus.mem_rd = 5'd3; bus.mem_val = 32'hAA;
    bus.wb_regwen  = 1'b1; bus.wb_rd  = 5'd3; bus.wb_val  = 32'hBB;
    #1;
    checks += 2;
    if (bus.alu_porta !== 32'hAA) begin failures++; $display("FAIL fwd_mem_porta got=%h exp=aa", bus.alu_porta); end
    if (bus.alu_portb !== 32'hAA) begin failures++; $display("FAIL fwd_mem_portb got=%h exp=aa", bus.alu_portb); end
    bus.mem_regwen = 1'b0;
    #1;
    checks += 1;
    if (bus.alu_porta !== 32'hBB) begin failures++; $display("FAIL fwd_wb_porta got=%h exp=bb", bus.alu_porta); end
    bus.wb_regwen = 1'b0;
    #1;
    checks += 2;
    if (bus.alu_porta !== 32'h11) begin failures++; $display("FAIL fwd_none_porta got=%h exp=11", bus.alu_porta); end
    if (bus.alu_portb !== 32'h22) begin failures++; $display("FAIL fwd_none_portb got=%h exp=22", bus.alu_portb); end
    drive(ALU_OR, 5'd0, 32'h55, 5'd0, 32'h66, 32'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    tick();
    idle();
    bus.mem_regwen = 1'b1; bus.mem_rd = 5'd0; bus.mem_val = 32'hAA;
    bus.wb_regwen  = 1'b1; bus.wb_rd  = 5'd0; bus.wb_val  = 32'hBB;
    #1;
    checks += 2;
    if (bus.alu_porta !== 32'h55) begin failures++; $display("FAIL fwd_r0_porta got=%h exp=55", bus.alu_porta); end
    if (bus.alu_portb !== 32'h66) begin failures++; $display("FAIL fwd_r0_portb got=%h exp=66", bus.alu_portb); end
    idle();
    tick();
    $display("txn forwarding: MEM over WB, r0 never forwarded");
  endtask

  task automatic test_stall();
    drive(ALU_ADD, 5'd1, 32'd10, 5'd0, 32'd0, 32'd20, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    drive(ALU_SUB, 5'd2, 32'd100, 5'd6, 32'd999, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    idle();
    bus.stall = 1'b1;
    bus.wb_regwen = 1'b1;
    bus.wb_rd = 5'd6;
    for (int i = 1; i <= 3; i++) begin
      bus.wb_val = i;
      #1;
      checks += 2;
      if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", bus.id_ready); end
      if (bus.alu_portb !== word_t'(i)) begin failures++; $display("FAIL stall_portb got=%h exp=%h", bus.alu_portb, i); end
      tick();
      checks += 3;
      if (bus.ex_result !== 32'd30) begin failures++; $display("FAIL stall_hold_result got=%h exp=1e", bus.ex_result); end
      if (bus.ex_rd !== 5'd9) begin failures++; $display("FAIL stall_hold_rd got=%0d exp=9", bus.ex_rd); end
      if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid got=%b exp=1", bus.ex_valid); end
    end
    bus.stall = 1'b0;
    tick();
    checks += 2;
    if (bus.ex_result !== 32'd97) begin failures++; $display("FAIL stall_release_result got=%h exp=61", bus.ex_result); end
    if (bus.ex_rd !== 5'd10) begin failures++; $display("FAIL stall_release_rd got=%0d exp=10", bus.ex_rd); end
    idle();
    $display("txn stall: SUB 100-3 -> %0d", bus.ex_result);
  endtask

  task automatic test_trap();
    drive(ALU_ADD, 5'd1, 32'h7FFFFFFF, 5'd0, 32'd0, 32'd1, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    drive(ALU_ADD, 5'd1, 32'd1, 5'd0, 32'd0, 32'd1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    checks += 1;
    if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL trap_pre_ready got=%b exp=1", bus.id_ready); end
    tick();
    idle();
    checks += 5;
    if (bus.ex_ovf_exc !== 1'b1) begin failures++; $display("FAIL trap_ovf got=%b exp=1", bus.ex_ovf_exc); end
    if (bus.ex_regwen !== 1'b0) begin failures++; $display("FAIL trap_regwen got=%b exp=0", bus.ex_regwen); end
    if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL trap_valid got=%b exp=1", bus.ex_valid); end
    if (bus.ex_rd !== 5'd5) begin failures++; $display("FAIL trap_rd got=%0d exp=5", bus.ex_rd); end
    if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL trap_ready got=%b exp=0", bus.id_ready); end
    tick();
    checks += 3;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL trap2_valid got=%b exp=0", bus.ex_valid); end
    if (bus.ex_ovf_exc !== 1'b1) begin failures++; $display("FAIL trap2_ovf got=%b exp=1", bus.ex_ovf_exc); end
    if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL trap2_ready got=%b exp=0", bus.id_ready); end
    tick();
    checks += 1;
    if (bus.ex_ovf_exc !== 1'b1) begin failures++; $display("FAIL trap_sticky got=%b exp=1", bus.ex_ovf_exc); end
    $display("txn trap: ADD 7fffffff+1 raised sticky overflow");
  endtask

  task automatic test_flush_in_trap();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    #1;
    checks += 1;
    if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_during got=%b exp=0", bus.id_ready); end
    tick();
    bus.flush = 1'b0;
    #1;
    checks += 4;
    if (bus.ex_ovf_exc !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", bus.ex_ovf_exc); end
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.ex_valid); end
    if (bus.ex_regwen !== 1'b0) begin failures++; $display("FAIL flush_regwen got=%b exp=0", bus.ex_regwen); end
    if (bus.id_ready !== 1'b0) begin failures++; $display("FAIL flush_stalled_ready got=%b exp=0", bus.id_ready); end
    bus.stall = 1'b0;
    #1;
    checks += 1;
    if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL flush_run_ready got=%b exp=1", bus.id_ready); end
    tick();
    checks += 1;
    if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL flush_younger_dropped got=%b exp=0", bus.ex_valid); end
    // Same overflow without the check enabled: plain wraparound, no trap.
    drive(ALU_ADD, 5'd1, 32'h7FFFFFFF, 5'd0, 32'd0, 32'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    checks += 6;
    if (bus.ex_result !== 32'h80000000) begin failures++; $display("FAIL nochk_result got=%h exp=80000000", bus.ex_result); end
    if (bus.ex_neg !== 1'b1) begin failures++; $display("FAIL nochk_neg got=%b exp=1", bus.ex_neg); end
    if (bus.ex_ovf_exc !== 1'b0) begin failures++; $display("FAIL nochk_ovf got=%b exp=0", bus.ex_ovf_exc); end
    if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL nochk_valid got=%b exp=1", bus.ex_valid); end
    if (bus.ex_regwen !== 1'b1) begin failures++; $display("FAIL nochk_regwen got=%b exp=1", bus.ex_regwen); end
    if (bus.id_ready !== 1'b1) begin failures++; $display("FAIL nochk_ready got=%b exp=1", bus.id_ready); end
    $display("txn flush: trap cleared; unchecked overflow -> %h", bus.ex_result);
  endtask

  task automatic test_random();
    bit       m_trap;
    bit       o_valid, o_alusrc, o_regwen, o_ovf;
    aluop_t   o_op;
    regbits_t o_rs, o_rt, o_rd;
    word_t    o_rsv, o_rtv, o_imm;
    bit       e_valid, e_regwen, e_zero, e_neg, e_ovf;
    word_t    e_result;
    regbits_t e_rd;
    word_t    a, b;
    logic [32:0] res;
    bit       adv, trap;

    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    m_trap = 0;
    o_valid = 0; o_op = ALU_ADD; o_rs = '0; o_rt = '0; o_rd = '0;
    o_rsv = '0; o_rtv = '0; o_imm = '0; o_alusrc = 0; o_regwen = 0; o_ovf = 0;
    e_valid = 0; e_regwen = 0; e_zero = 0; e_neg = 0; e_ovf = 0;
    e_result = '0; e_rd = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.id_valid   = ($urandom_range(0, 3) != 0);
      bus.id_aluop   = aluop_t'(4'($urandom_range(0, 9)));
      bus.id_rs      = regbits_t'($urandom_range(0, 7));
      bus.id_rt      = regbits_t'($urandom_range(0, 7));
      bus.id_rs_val  = $urandom;
      bus.id_rt_val  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      bus.id_imm     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      bus.id_alusrc  = ($urandom_range(0, 1) == 0);
      bus.id_rd      = regbits_t'($urandom);
      bus.id_regwen  = ($urandom_range(0, 1) == 0);
      bus.id_ovf_chk = ($urandom_range(0, 2) == 0);
      bus.mem_regwen = ($urandom_range(0, 1) == 0);
      bus.wb_regwen  = ($urandom_range(0, 1) == 0);
      bus.mem_rd     = regbits_t'($urandom_range(0, 7));
      bus.wb_rd      = regbits_t'($urandom_range(0, 7));
      bus.mem_val    = $urandom;
      bus.wb_val     = $urandom;
      bus.stall      = ($urandom_range(0, 3) == 0);
      bus.flush      = ($urandom_range(0, 11) == 0);
      #1;
      a = fwd_ref(o_rs, o_rsv);
      b = o_alusrc ? o_imm : fwd_ref(o_rt, o_rtv);
      adv = !m_trap && !bus.stall && !bus.flush;
      checks += 4;
      if (bus.alu_porta !== a) begin failures++; $display("FAIL rnd_porta cyc=%0d got=%h exp=%h", cyc, bus.alu_porta, a); end
      if (bus.alu_portb !== b) begin failures++; $display("FAIL rnd_portb cyc=%0d got=%h exp=%h", cyc, bus.alu_portb, b); end
      if (bus.alu_op !== o_op) begin failures++; $display("FAIL rnd_op cyc=%0d got=%0d exp=%0d", cyc, bus.alu_op, o_op); end
      if (bus.id_ready !== adv) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.id_ready, adv); end
      res  = alu_ref(o_op, a, b);
      trap = adv && o_valid && o_ovf && res[32];

      tick();
      if (bus.flush) begin
        o_valid = 0; e_valid = 0; e_ovf = 0; e_regwen = 0; m_trap = 0;
      end else if (adv) begin
        e_valid  = o_valid;
        e_result = res[31:0];
        e_rd     = o_rd;
        e_regwen = o_regwen && !trap;
        e_zero   = (res[31:0] == 32'd0);
        e_neg    = res[31];
        e_ovf    = trap;
        if (trap) begin
          m_trap  = 1;
          o_valid = 0;
        end else begin
          o_valid = bus.id_valid; o_op = bus.id_aluop; o_rs = bus.id_rs; o_rt = bus.id_rt;
          o_rsv = bus.id_rs_val; o_rtv = bus.id_rt_val; o_imm = bus.id_imm;
          o_alusrc = bus.id_alusrc; o_rd = bus.id_rd; o_regwen = bus.id_regwen;
          o_ovf = bus.id_ovf_chk;
        end
      end else if (m_trap) begin
        e_valid = 0;
      end

      checks += 2;
      if (bus.ex_valid !== e_valid) begin failures++; $display("FAIL rnd_ex_valid cyc=%0d got=%b exp=%b", cyc, bus.ex_valid, e_valid); end
      if (bus.ex_ovf_exc !== e_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, bus.ex_ovf_exc, e_ovf); end
      if (e_valid) begin
        checks += 5;
        if (bus.ex_result !== e_result) begin failures++; $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, bus.ex_result, e_result); end
        if (bus.ex_rd !== e_rd) begin failures++; $display("FAIL rnd_rd cyc=%0d got=%0d exp=%0d", cyc, bus.ex_rd, e_rd); end
        if (bus.ex_regwen !== e_regwen) begin failures++; $display("FAIL rnd_regwen cyc=%0d got=%b exp=%b", cyc, bus.ex_regwen, e_regwen); end
        if (bus.ex_zero !== e_zero) begin failures++; $display("FAIL rnd_zero cyc=%0d got=%b exp=%b", cyc, bus.ex_zero, e_zero); end
        if (bus.ex_neg !== e_neg) begin failures++; $display("FAIL rnd_neg cyc=%0d got=%b exp=%b", cyc, bus.ex_neg, e_neg); end
        $display("txn rnd cyc=%0d rd=%0d result=%h ovf=%b", cyc, e_rd, e_result, e_ovf);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_forwarding();
    test_stall();
    test_trap();
    test_flush_in_trap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
